// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle shared by the arbiter and its producers.
// The slave modport is the arbiter's view; the master modport is the
// producer/decode side (pipeline writeback, LU, decode operand queries).
interface wb_write_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Pipeline writeback request
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [WIDTH-1:0]      wb_data;

    // Long-latency unit result handshake
    logic                  lu_valid;
    logic                  lu_ready;
    logic [ADDR_WIDTH-1:0] lu_addr;
    logic [WIDTH-1:0]      lu_data;

    // Register-file write port
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] W_addr;
    logic [WIDTH-1:0]      W_data;

    // Decode operand busy queries
    logic [ADDR_WIDTH-1:0] rs_addr;
    logic [ADDR_WIDTH-1:0] rt_addr;
    logic                  rs_busy;
    logic                  rt_busy;

    // Occupancy, including squashed slots
    logic [CNT_W-1:0]      fifo_count;

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  lu_valid, lu_addr, lu_data,
        input  rs_addr, rt_addr,
        output lu_ready,
        output RegWrite, W_addr, W_data,
        output rs_busy, rt_busy,
        output fifo_count
    );

    modport master (
        output wb_valid, wb_addr, wb_data,
        output lu_valid, lu_addr, lu_data,
        output rs_addr, rt_addr,
        input  lu_ready,
        input  RegWrite, W_addr, W_data,
        input  rs_busy, rt_busy,
        input  fifo_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter.
// Pipeline writeback always owns the port. LU results wait in a small
// in-order FIFO and drain into cycles the pipeline leaves idle. A pipeline
// write squashes older queued LU results to the same register, so the
// program-order-last write is the one that sticks. Busy flags report
// registers that still have an unsquashed LU result queued.
//
// LU handshake: a transfer happens on a posedge where lu_valid && lu_ready.
// lu_ready depends only on the registered occupancy (a pop in the same
// cycle does not raise it). While lu_valid=1 and lu_ready=0 the LU keeps
// lu_addr/lu_data stable. A transfer to register 0 completes the handshake
// but the result is dropped.
module wb_write_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4   // power of two, at least 2
) (
    input logic                clk,
    input logic                rst,
    wb_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; a slot stays occupied after being squashed
    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
    logic [WIDTH-1:0]      ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_valid_next;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  wb_eff;
    logic                  lu_fire;
    logic                  lu_enq;
    logic                  pop;
    logic                  head_valid;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WIDTH-1:0]      head_data;
    logic                  rs_hit;
    logic                  rt_hit;

    // Writes to register 0 are architecturally void, so they are not requests
    assign wb_eff     = bus.wb_valid && (bus.wb_addr != '0);

    assign bus.lu_ready = !rst && (count < CNT_W'(DEPTH));
    assign lu_fire    = bus.lu_valid && bus.lu_ready;
    assign lu_enq     = lu_fire && (bus.lu_addr != '0);

    // The FIFO only gets the port when the pipeline leaves it idle
    assign pop        = !wb_eff && (count != '0);

    assign head_valid = ent_valid[rd_ptr];
    assign head_addr  = ent_addr[rd_ptr];
    assign head_data  = ent_data[rd_ptr];

    assign bus.fifo_count = count;

    // Next entry-valid vector: squash older matches, retire head, mark new slot
    always_comb begin
        ent_valid_next = ent_valid;
        if (wb_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_addr[i] == bus.wb_addr) begin
                    ent_valid_next[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            ent_valid_next[rd_ptr] = 1'b0;
        end
        // Applied last: a result enqueued alongside a matching pipeline
        // write is program-order later and must survive
        if (lu_enq) begin
            ent_valid_next[wr_ptr] = 1'b1;
        end
    end

    // Operand busy lookup against registered, unsquashed entries only
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == bus.rs_addr)) begin
                rs_hit = 1'b1;
            end
            if (ent_valid[i] && (ent_addr[i] == bus.rt_addr)) begin
                rt_hit = 1'b1;
            end
        end
    end

    assign bus.rs_busy = (bus.rs_addr != '0) && rs_hit;
    assign bus.rt_busy = (bus.rt_addr != '0) && rt_hit;

    // FIFO slot contents and validity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
            ent_valid <= '0;
        end else begin
            if (lu_enq) begin
                ent_addr[wr_ptr] <= bus.lu_addr;
                ent_data[wr_ptr] <= bus.lu_data;
            end
            ent_valid <= ent_valid_next;
        end
    end

    // Circular pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (lu_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({lu_enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port: pipeline first, then FIFO head, else idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.RegWrite <= 1'b0;
            bus.W_addr   <= '0;
            bus.W_data   <= '0;
        end else if (wb_eff) begin
            bus.RegWrite <= 1'b1;
            bus.W_addr   <= bus.wb_addr;
            bus.W_data   <= bus.wb_data;
        end else if (pop) begin
            // A squashed head still burns this slot but writes nothing
            bus.RegWrite <= head_valid;
            if (head_valid) begin
                bus.W_addr <= head_addr;
                bus.W_data <= head_data;
            end
        end else begin
            bus.RegWrite <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of the write-port rules.
module tb_wb_write_arbiter;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    wb_write_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) bus ();

    wb_write_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Hard stop in case the run never reaches its summary
    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic lv, input logic [AW-1:0] la, input logic [W-1:0] ld);
        bus.wb_valid = wv;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.lu_valid = lv;
        bus.lu_addr  = la;
        bus.lu_data  = ld;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.rs_addr = 5'd1;
        bus.rt_addr = 5'd2;
        tick();
        tick();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
        checks++; if (bus.W_addr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bus.W_addr); end
        checks++; if (bus.W_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.W_data); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
        checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got %b want 0", bus.lu_ready); end
        checks++; if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", bus.rs_busy, bus.rt_busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL release_lu_ready got %b want 1", bus.lu_ready); end
    endtask

    task automatic test_single_lu;
        drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h11);
        bus.rs_addr = 5'd9;
        bus.rt_addr = 5'd0;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.lu_ready); end
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.fifo_count); end
        checks++; if (bus.rs_busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b want 1", bus.rs_busy); end
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL single_early_write got %b want 0", bus.RegWrite); end
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== 5'd9 || bus.W_data !== 32'h11)
            begin errors++; $display("FAIL single_write got we=%b a=%0d d=%h want 1/9/11", bus.RegWrite, bus.W_addr, bus.W_data); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.fifo_count); end
        checks++; if (bus.rs_busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got %b want 0", bus.rs_busy); end
    endtask

    task automatic test_priority;
        logic [AW-1:0] aq[$];
        logic          exp_rdy;
        int            n;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        n = 0;
        exp_q.delete();
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
        // Pipeline busy every cycle: LU results pile up
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, AW'(8 + k), W'(32'h800 + k), n < 5, AW'(20 + n), W'(32'h100 + n));
            #1;
            exp_rdy = aq.size() < D;
            checks++; if (bus.lu_ready !== exp_rdy) begin errors++; $display("FAIL prio_ready k=%0d got %b want %b", k, bus.lu_ready, exp_rdy); end
            if (n < 5 && exp_rdy) begin
                aq.push_back(AW'(20 + n));
                exp_q.push_back(W'(32'h100 + n));
                n++;
            end
            tick();
            checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== AW'(8 + k) || bus.W_data !== W'(32'h800 + k))
                begin errors++; $display("FAIL prio_wb k=%0d got we=%b a=%0d d=%h", k, bus.RegWrite, bus.W_addr, bus.W_data); end
            checks++; if (bus.fifo_count !== 3'(aq.size())) begin errors++; $display("FAIL prio_count k=%0d got %0d want %0d", k, bus.fifo_count, aq.size()); end
        end
        // Pipeline idle: drain in push order, pending LU result joins after first pop
        for (int k = 0; k < 12 && (aq.size() > 0 || n < 5); k++) begin
            drive(1'b0, '0, '0, n < 5, AW'(20 + n), W'(32'h100 + n));
            #1;
            exp_rdy = aq.size() < D;
            checks++; if (bus.lu_ready !== exp_rdy) begin errors++; $display("FAIL drain_ready k=%0d got %b want %b", k, bus.lu_ready, exp_rdy); end
            ea = aq.pop_front();
            ed = exp_q.pop_front();
            if (n < 5 && exp_rdy) begin
                aq.push_back(AW'(20 + n));
                exp_q.push_back(W'(32'h100 + n));
                n++;
            end
            tick();
            checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== ea || bus.W_data !== ed)
                begin errors++; $display("FAIL drain_write k=%0d got we=%b a=%0d d=%h want 1/%0d/%h", k, bus.RegWrite, bus.W_addr, bus.W_data, ea, ed); end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        checks++; if (n != 5 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drain_end pushes=%0d count=%0d want 5/0", n, bus.fifo_count); end
    endtask

    task automatic test_squash;
        drive(1'b0, '0, '0, 1'b1, 5'd16, 32'hAA);
        bus.rs_addr = 5'd16;
        bus.rt_addr = 5'd0;
        tick();
        drive(1'b1, 5'd16, 32'hBB, 1'b0, '0, '0);
        #1;
        checks++; if (bus.rs_busy !== 1'b1 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL squash_pre busy=%b count=%0d want 1/1", bus.rs_busy, bus.fifo_count); end
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== 5'd16 || bus.W_data !== 32'hBB)
            begin errors++; $display("FAIL squash_wb got we=%b a=%0d d=%h want 1/16/bb", bus.RegWrite, bus.W_addr, bus.W_data); end
        checks++; if (bus.rs_busy !== 1'b0 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL squash_post busy=%b count=%0d want 0/1", bus.rs_busy, bus.fifo_count); end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        checks++; if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL squash_pop we=%b count=%0d want 0/0", bus.RegWrite, bus.fifo_count); end
        checks++; if (bus.W_addr !== 5'd16 || bus.W_data !== 32'hBB) begin errors++; $display("FAIL squash_hold a=%0d d=%h want 16/bb", bus.W_addr, bus.W_data); end
        // Same-cycle LU enqueue is younger than the pipeline write: not squashed
        drive(1'b1, 5'd17, 32'hDD, 1'b1, 5'd17, 32'hCC);
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd17;
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.W_data !== 32'hDD) begin errors++; $display("FAIL same_wb we=%b d=%h want 1/dd", bus.RegWrite, bus.W_data); end
        checks++; if (bus.rt_busy !== 1'b1 || bus.fifo_count !== 3'd1) begin errors++; $display("FAIL same_busy busy=%b count=%0d want 1/1", bus.rt_busy, bus.fifo_count); end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== 5'd17 || bus.W_data !== 32'hCC)
            begin errors++; $display("FAIL same_lu got we=%b a=%0d d=%h want 1/17/cc", bus.RegWrite, bus.W_addr, bus.W_data); end
        checks++; if (bus.rt_busy !== 1'b0) begin errors++; $display("FAIL same_busy0 got %b want 0", bus.rt_busy); end
    endtask

    task automatic test_addr_zero;
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        bus.rs_addr = 5'd0;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", bus.lu_ready); end
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        checks++; if (bus.fifo_count !== 3'd0 || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL zero_accept count=%0d we=%b want 0/0", bus.fifo_count, bus.RegWrite); end
        checks++; if (bus.W_addr !== 5'd17 || bus.W_data !== 32'hCC) begin errors++; $display("FAIL zero_hold a=%0d d=%h want 17/cc", bus.W_addr, bus.W_data); end
        checks++; if (bus.rs_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", bus.rs_busy); end
        tick();
        checks++; if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL zero_after we=%b count=%0d want 0/0", bus.RegWrite, bus.fifo_count); end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, AW'(1 + k), W'(32'h200 + k), 1'b1, AW'(4 + k), W'(32'h300 + k));
            tick();
        end
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL mid_fill got %0d want 3", bus.fifo_count); end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.rs_addr = 5'd5;
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== 5'd4 || bus.fifo_count !== 3'd2)
            begin errors++; $display("FAIL mid_first we=%b a=%0d count=%0d want 1/4/2", bus.RegWrite, bus.W_addr, bus.fifo_count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0 || bus.lu_ready !== 1'b0)
            begin errors++; $display("FAIL mid_rst we=%b count=%0d ready=%b want 0/0/0", bus.RegWrite, bus.fifo_count, bus.lu_ready); end
        checks++; if (bus.rs_busy !== 1'b0 || bus.W_addr !== 5'd0) begin errors++; $display("FAIL mid_rst_state busy=%b a=%0d want 0/0", bus.rs_busy, bus.W_addr); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", bus.lu_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_stale k=%0d we=%b count=%0d", k, bus.RegWrite, bus.fifo_count); end
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] aq[$];
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                drive(1'b0, '0, '0, 1'b1, AW'(1 + i / 2), W'(32'h400 + i / 2));
                aq.push_back(AW'(1 + i / 2));
                exp_q.push_back(W'(32'h400 + i / 2));
            end else begin
                drive(1'b0, '0, '0, 1'b0, '0, '0);
            end
            tick();
            if (i % 2 == 1) begin
                ea = aq.pop_front();
                ed = exp_q.pop_front();
                checks++; if (bus.RegWrite !== 1'b1 || bus.W_addr !== ea || bus.W_data !== ed)
                    begin errors++; $display("FAIL wrap_write i=%0d got we=%b a=%0d d=%h want 1/%0d/%h", i, bus.RegWrite, bus.W_addr, bus.W_data, ea, ed); end
            end else begin
                checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL wrap_idle i=%0d got we=%b want 0", i, bus.RegWrite); end
            end
        end
        checks++; if (bus.fifo_count !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_end count=%0d left=%0d want 0/0", bus.fifo_count, exp_q.size()); end
    endtask

    task automatic test_random;
        logic [AW-1:0] qa[$];
        logic [W-1:0]  qd[$];
        bit            qv[$];
        logic          m_we;
        logic [AW-1:0] m_wa;
        logic [W-1:0]  m_wd;
        logic          wv, lv, lu_hold, exp_rdy, exp_rs, exp_rt, hv;
        logic [AW-1:0] wa, la, ra, ta, ha;
        logic [W-1:0]  wd, ld, hd;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        lu_hold = 1'b0; lv = 1'b0; la = '0; ld = '0;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            wv = ($urandom_range(0, 99) < 40);
            wa = AW'($urandom_range(0, 7));
            wd = $urandom;
            if (!lu_hold) begin
                lv = ($urandom_range(0, 99) < 65);
                la = AW'($urandom_range(0, 7));
                ld = $urandom;
            end
            ra = AW'($urandom_range(0, 7));
            ta = AW'($urandom_range(0, 7));
            drive(wv, wa, wd, lv, la, ld);
            bus.rs_addr = ra;
            bus.rt_addr = ta;
            #1;
            exp_rdy = qa.size() < D;
            exp_rs = 1'b0;
            exp_rt = 1'b0;
            foreach (qa[i]) begin
                if (qv[i] && qa[i] == ra && ra != 0) exp_rs = 1'b1;
                if (qv[i] && qa[i] == ta && ta != 0) exp_rt = 1'b1;
            end
            checks++; if (bus.lu_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.lu_ready, exp_rdy); end
            checks++; if (bus.rs_busy !== exp_rs || bus.rt_busy !== exp_rt)
                begin errors++; $display("FAIL rnd_busy c=%0d got %b%b want %b%b", c, bus.rs_busy, bus.rt_busy, exp_rs, exp_rt); end
            checks++; if (bus.fifo_count !== 3'(qa.size())) begin errors++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bus.fifo_count, qa.size()); end
            // Model of the coming edge
            if (wv && wa != 0) begin
                m_we = 1'b1; m_wa = wa; m_wd = wd;
                foreach (qa[i]) if (qa[i] == wa) qv[i] = 1'b0;
            end else if (qa.size() > 0) begin
                ha = qa.pop_front();
                hd = qd.pop_front();
                hv = qv.pop_front();
                m_we = hv;
                if (hv) begin m_wa = ha; m_wd = hd; end
            end else begin
                m_we = 1'b0;
            end
            if (lv && exp_rdy && la != 0) begin
                qa.push_back(la); qd.push_back(ld); qv.push_back(1'b1);
            end
            lu_hold = lv && !exp_rdy;
            tick();
            checks++; if (bus.RegWrite !== m_we || bus.W_addr !== m_wa || bus.W_data !== m_wd)
                begin errors++; $display("FAIL rnd_port c=%0d got we=%b a=%0d d=%h want %b/%0d/%h", c, bus.RegWrite, bus.W_addr, bus.W_data, m_we, m_wa, m_wd); end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        test_reset();
        test_single_lu();
        test_priority();
        test_squash();
        test_addr_zero();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
